// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: VDP fetch port, CPU req/ack port and the VRAM port.
// slave is the arbiter side; master is the surrounding system (VDP, CPU, RAM).
interface vram_arbiter_if #(
    parameter int unsigned AW = 13
);
    logic          vdp_req;
    logic [AW-1:0] vdp_addr;
    logic [47:0]   vdp_data;
    logic          vdp_overrun;

    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [2:0]    rd_plane;
    logic [5:0]    wr_mask;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          cpu_wait;

    logic [AW-1:0] ram_addr;
    logic [5:0]    ram_we;
    logic [7:0]    ram_din;
    logic [47:0]   ram_dout;

    modport slave (
        input  vdp_req, vdp_addr, cpu_rd, cpu_wr, cpu_addr, cpu_din, rd_plane, wr_mask,
               ram_dout,
        output vdp_data, vdp_overrun, cpu_dout, cpu_ack, cpu_wait, ram_addr, ram_we, ram_din
    );

    modport master (
        output vdp_req, vdp_addr, cpu_rd, cpu_wr, cpu_addr, cpu_din, rd_plane, wr_mask,
               ram_dout,
        input  vdp_data, vdp_overrun, cpu_dout, cpu_ack, cpu_wait, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port 6-plane VRAM between VDP fetches (strict priority) and CPU req/ack.
// Optional power-on clear sweep is enabled by defining VRAM_CLEAR_EN.
module vram_arbiter #(
    parameter int unsigned AW    = 13,
    parameter int unsigned DEPTH = 8192
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StVrd, StVlat, StCwr, StCrd, StClat, StCidle, StClr
    } state_e;

`ifdef VRAM_CLEAR_EN
    localparam state_e StReset = StClr;
`else
    localparam state_e StReset = StIdle;
`endif

    if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_depth_chk
        $error("vram_arbiter: DEPTH must be in 1..2**AW");
    end

    state_e        state_q, state_d;
    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    logic          overrun_q, overrun_d;
    logic [47:0]   vdp_data_q, vdp_data_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_din_q, ram_din_d;
    logic [7:0]    rd_byte;
    logic          ack;
    logic [5:0]    we;
    logic          clr_busy;
`ifdef VRAM_CLEAR_EN
    logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

    always_comb begin
        case (bus.rd_plane)
            3'd1:    rd_byte = bus.ram_dout[7:0];
            3'd2:    rd_byte = bus.ram_dout[15:8];
            3'd3:    rd_byte = bus.ram_dout[23:16];
            3'd4:    rd_byte = bus.ram_dout[31:24];
            3'd5:    rd_byte = bus.ram_dout[39:32];
            3'd6:    rd_byte = bus.ram_dout[47:40];
            default: rd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        vpend_d    = vpend_q;
        vaddr_d    = vaddr_q;
        overrun_d  = overrun_q;
        vdp_data_d = vdp_data_q;
        cpu_dout_d = cpu_dout_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ack        = 1'b0;
        we         = 6'h00;
`ifdef VRAM_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif

        case (state_q)
            StIdle, StCidle: begin
                // CIDLE is the CPU's drop-request gap: only the VDP may start here.
                if (vpend_q || bus.vdp_req) begin
                    state_d    = StVrd;
                    ram_addr_d = bus.vdp_req ? bus.vdp_addr : vaddr_q;
                end else if (state_q == StIdle && bus.cpu_wr) begin
                    state_d    = StCwr;
                    ram_addr_d = bus.cpu_addr;
                    ram_din_d  = bus.cpu_din;
                end else if (state_q == StIdle && bus.cpu_rd) begin
                    state_d    = StCrd;
                    ram_addr_d = bus.cpu_addr;
                end else begin
                    state_d = StIdle;
                end
            end
            StVrd: begin
                vpend_d = 1'b0;
                state_d = StVlat;
            end
            StVlat: begin
                vdp_data_d = bus.ram_dout;
                state_d    = StIdle;
            end
            StCwr: begin
                we      = bus.wr_mask;
                ack     = 1'b1;
                state_d = StCidle;
            end
            StCrd: begin
                state_d = StClat;
            end
            StClat: begin
                cpu_dout_d = rd_byte;
                ack        = 1'b1;
                state_d    = StCidle;
            end
`ifdef VRAM_CLEAR_EN
            StClr: begin
                we         = 6'h3F;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Capture after the state logic so a strobe landing in VRD is not lost by its clear.
        if (bus.vdp_req) begin
            if (vpend_q) begin
                overrun_d = 1'b1;
            end
            vpend_d = 1'b1;
            vaddr_d = bus.vdp_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReset;
            vpend_q    <= 1'b0;
            vaddr_q    <= '0;
            overrun_q  <= 1'b0;
            vdp_data_q <= '0;
            cpu_dout_q <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
`ifdef VRAM_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vpend_q    <= vpend_d;
            vaddr_q    <= vaddr_d;
            overrun_q  <= overrun_d;
            vdp_data_q <= vdp_data_d;
            cpu_dout_q <= cpu_dout_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
`ifdef VRAM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    assign clr_busy        = (state_q == StClr);
    assign bus.cpu_ack     = ack;
    assign bus.cpu_wait    = clr_busy | ((bus.cpu_rd | bus.cpu_wr) & ~ack);
    // Read data is live from the RAM in the ack cycle and held afterwards.
    assign bus.cpu_dout    = (state_q == StClat) ? rd_byte : cpu_dout_q;
    assign bus.vdp_data    = vdp_data_q;
    assign bus.vdp_overrun = overrun_q;
    assign bus.ram_we      = we;
`ifdef VRAM_CLEAR_EN
    assign bus.ram_addr    = clr_busy ? clr_addr_q : ram_addr_q;
    assign bus.ram_din     = clr_busy ? 8'h00 : ram_din_q;
`else
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;
`endif

endmodule
